// File: rtl/lnrv_dtcm_ctrl.sv
// DTCM controller: LSU command port to a single-port synchronous SRAM.
// Range and alignment checks, one-cycle SRAM read pipeline, 4-entry in-order response FIFO.
module lnrv_dtcm_ctrl #(
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int unsigned AW        = 12
) (
    input  logic          clk,
    input  logic          reset_n,

    input  logic          lsu_cmd_vld,
    output logic          lsu_cmd_rdy,
    input  logic          lsu_cmd_write,
    input  logic [31:0]   lsu_cmd_addr,
    input  logic [31:0]   lsu_cmd_wdata,
    input  logic [3:0]    lsu_cmd_wstrb,
    input  logic [2:0]    lsu_cmd_size,

    output logic          lsu_rsp_vld,
    input  logic          lsu_rsp_rdy,
    output logic [31:0]   lsu_rsp_rdata,
    output logic          lsu_rsp_err,

    output logic          sram_cs,
    output logic          sram_we,
    output logic [AW-1:0] sram_addr,
    output logic [3:0]    sram_wem,
    output logic [31:0]   sram_din,
    input  logic [31:0]   sram_dout
);

    typedef struct packed {
        logic        err;
        logic [31:0] data;
    } rsp_t;

    logic       in_win;
    logic       aligned;
    logic       legal;
    logic       cmd_hs;
    logic       sram_acc;

    logic       s1_vld;
    logic       s1_rd;
    logic       s1_err;

    rsp_t       fifo [4];
    logic [1:0] wr_ptr;
    logic [1:0] rd_ptr;
    logic [2:0] fifo_cnt;
    logic       push;
    logic       pop;
    rsp_t       push_ent;

    // BASE_ADDR is window-aligned, so the range check reduces to matching the upper bits.
    assign in_win = (lsu_cmd_addr[31:AW+2] == BASE_ADDR[31:AW+2]);

    always_comb begin
        aligned = 1'b0;
        case (lsu_cmd_size)
            3'd0:    aligned = 1'b1;
            3'd1:    aligned = ~lsu_cmd_addr[0];
            3'd2:    aligned = (lsu_cmd_addr[1:0] == 2'b00);
            default: aligned = 1'b0;
        endcase
    end

    assign legal    = in_win & aligned;
    assign cmd_hs   = lsu_cmd_vld & lsu_cmd_rdy;
    assign sram_acc = cmd_hs & legal & reset_n;

    assign sram_cs   = sram_acc;
    assign sram_we   = sram_acc & lsu_cmd_write;
    assign sram_addr = lsu_cmd_addr[AW+1:2];
    assign sram_wem  = (sram_acc & lsu_cmd_write) ? lsu_cmd_wstrb : 4'h0;
    assign sram_din  = lsu_cmd_wdata;

    // Counting s1 as occupied reserves its FIFO slot, so ready never looks at lsu_rsp_rdy.
    assign lsu_cmd_rdy = ((fifo_cnt + 3'(s1_vld)) < 3'd4);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_vld <= 1'b0;
            s1_rd  <= 1'b0;
            s1_err <= 1'b0;
        end else begin
            s1_vld <= cmd_hs;
            s1_rd  <= cmd_hs & ~lsu_cmd_write;
            s1_err <= cmd_hs & ~legal;
        end
    end

    assign push = s1_vld;
    assign pop  = lsu_rsp_vld & lsu_rsp_rdy;

    always_comb begin
        push_ent.err  = s1_err;
        push_ent.data = (s1_rd & ~s1_err) ? sram_dout : '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < 4; i++) begin
                fifo[i] <= '0;
            end
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) begin
                fifo[wr_ptr] <= push_ent;
                wr_ptr       <= wr_ptr + 2'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 3'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 3'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    assign lsu_rsp_vld   = (fifo_cnt != 3'd0);
    assign lsu_rsp_rdata = fifo[rd_ptr].data;
    assign lsu_rsp_err   = fifo[rd_ptr].err;

endmodule

// File: tb/tb_lnrv_dtcm_ctrl.sv
// Randomized bench for lnrv_dtcm_ctrl: behavioural SRAM, byte-level memory reference
// and an expected-response queue derived from the access rules.
module tb_lnrv_dtcm_ctrl;

    localparam int unsigned   TB_AW   = 6;
    localparam logic [31:0]   TB_BASE = 32'h8000_0000;
    localparam logic [32:0]   TB_WIN  = 33'd4 << TB_AW;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              lsu_cmd_vld = 1'b0;
    logic              lsu_cmd_rdy;
    logic              lsu_cmd_write = 1'b0;
    logic [31:0]       lsu_cmd_addr = '0;
    logic [31:0]       lsu_cmd_wdata = '0;
    logic [3:0]        lsu_cmd_wstrb = '0;
    logic [2:0]        lsu_cmd_size = '0;
    logic              lsu_rsp_vld;
    logic              lsu_rsp_rdy = 1'b0;
    logic [31:0]       lsu_rsp_rdata;
    logic              lsu_rsp_err;
    logic              sram_cs;
    logic              sram_we;
    logic [TB_AW-1:0]  sram_addr;
    logic [3:0]        sram_wem;
    logic [31:0]       sram_din;
    logic [31:0]       sram_dout;

    lnrv_dtcm_ctrl #(.BASE_ADDR(TB_BASE), .AW(TB_AW)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .lsu_cmd_vld   (lsu_cmd_vld),
        .lsu_cmd_rdy   (lsu_cmd_rdy),
        .lsu_cmd_write (lsu_cmd_write),
        .lsu_cmd_addr  (lsu_cmd_addr),
        .lsu_cmd_wdata (lsu_cmd_wdata),
        .lsu_cmd_wstrb (lsu_cmd_wstrb),
        .lsu_cmd_size  (lsu_cmd_size),
        .lsu_rsp_vld   (lsu_rsp_vld),
        .lsu_rsp_rdy   (lsu_rsp_rdy),
        .lsu_rsp_rdata (lsu_rsp_rdata),
        .lsu_rsp_err   (lsu_rsp_err),
        .sram_cs       (sram_cs),
        .sram_we       (sram_we),
        .sram_addr     (sram_addr),
        .sram_wem      (sram_wem),
        .sram_din      (sram_din),
        .sram_dout     (sram_dout)
    );

    always #5 clk = ~clk;

    // Behavioural SRAM: writes land at the edge, read data appears the following cycle.
    logic [31:0] sram_mem [1 << TB_AW];
    always @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < (1 << TB_AW); i++) sram_mem[i] <= '0;
            sram_dout <= '0;
        end else if (sram_cs) begin
            if (sram_we) begin
                for (int b = 0; b < 4; b++)
                    if (sram_wem[b]) sram_mem[sram_addr][8*b +: 8] <= sram_din[8*b +: 8];
            end else begin
                sram_dout <= sram_mem[sram_addr];
            end
        end
    end

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [2:0]  size;
    } cmd_t;

    typedef struct {
        int unsigned cyc;
        logic [31:0] data;
        logic        err;
    } exp_t;

    cmd_t        cmd_q [$];
    exp_t        exp_q [$];
    logic [31:0] ref_mem [1 << TB_AW];
    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    int unsigned n_acc = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h, expected %08h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic is_legal(input cmd_t c);
        logic [32:0] a;
        logic        in_rng;
        a      = {1'b0, c.addr};
        in_rng = (a >= {1'b0, TB_BASE}) && (a < ({1'b0, TB_BASE} + TB_WIN));
        if (c.size > 3'd2)                      return 1'b0;
        if (c.size == 3'd1 && c.addr[0])        return 1'b0;
        if (c.size == 3'd2 && c.addr[1:0] != 0) return 1'b0;
        return in_rng;
    endfunction

    function automatic int word_idx(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - TB_BASE;
        return int'(off >> 2);
    endfunction

    function automatic cmd_t mk(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [3:0] wstrb, input logic [2:0] size);
        cmd_t c;
        c.wr = wr; c.addr = addr; c.wdata = wdata; c.wstrb = wstrb; c.size = size;
        return c;
    endfunction

    function automatic cmd_t rand_cmd();
        cmd_t        c;
        int unsigned r;
        r       = $urandom_range(0, 15);
        c.wr    = 1'($urandom_range(0, 1));
        c.wdata = $urandom;
        c.wstrb = 4'($urandom_range(0, 15));
        c.size  = 3'($urandom_range(0, 2));
        c.addr  = TB_BASE + 32'($urandom_range(0, 7) * 4);
        if (c.size == 3'd0)      c.addr += 32'($urandom_range(0, 3));
        else if (c.size == 3'd1) c.addr += 32'($urandom_range(0, 1) * 2);
        if (r == 0)      c.addr = TB_BASE - 32'($urandom_range(1, 16));
        else if (r == 1) c.addr = TB_BASE + 32'(TB_WIN) + 32'($urandom_range(0, 16));
        else if (r == 2) c.addr = c.addr | 32'd1;
        else if (r == 3) c.size = 3'($urandom_range(3, 7));
        else if (r == 4) c.addr = TB_BASE + 32'($urandom_range(0, (1 << TB_AW) - 1) * 4);
        return c;
    endfunction

    // Per-cycle comparison at the falling edge; the model is updated for this cycle's handshakes.
    task automatic eval_cycle();
        logic  exp_rdy, exp_vld, hs, lg;
        cmd_t  c;
        exp_t  e;
        int    idx;
        exp_rdy = (exp_q.size() < 4);
        check("cmd_rdy", 32'(lsu_cmd_rdy), 32'(exp_rdy));
        exp_vld = (exp_q.size() > 0) && (exp_q[0].cyc + 2 <= cyc);
        check("rsp_vld", 32'(lsu_rsp_vld), 32'(exp_vld));
        if (exp_vld) begin
            check("rsp_rdata", lsu_rsp_rdata, exp_q[0].data);
            check("rsp_err", 32'(lsu_rsp_err), 32'(exp_q[0].err));
            if (lsu_rsp_rdy) void'(exp_q.pop_front());
        end
        hs = lsu_cmd_vld && exp_rdy && (cmd_q.size() > 0);
        lg = 1'b0;
        if (hs) begin
            c  = cmd_q[0];
            lg = is_legal(c);
        end
        check("sram_cs", 32'(sram_cs), 32'(hs && lg));
        check("sram_we", 32'(sram_we), 32'(hs && lg && c.wr));
        if (hs) begin
            e.cyc  = cyc;
            e.data = '0;
            e.err  = !lg;
            if (lg) begin
                idx = word_idx(c.addr);
                check("sram_addr", 32'(sram_addr), 32'(idx));
                check("sram_wem", 32'(sram_wem), c.wr ? 32'(c.wstrb) : 32'd0);
                check("sram_din", sram_din, c.wdata);
                if (c.wr) begin
                    for (int b = 0; b < 4; b++)
                        if (c.wstrb[b]) ref_mem[idx][8*b +: 8] = c.wdata[8*b +: 8];
                end else begin
                    e.data = ref_mem[idx];
                end
            end
            exp_q.push_back(e);
            void'(cmd_q.pop_front());
            n_acc++;
        end
    endtask

    // mode: 0 = rsp_rdy low, 1 = rsp_rdy high, 2 = random rsp_rdy
    task automatic run(input int unsigned n, input int unsigned mode);
        for (int unsigned i = 0; i < n; i++) begin
            if (cmd_q.size() > 0) begin
                lsu_cmd_vld   = 1'b1;
                lsu_cmd_write = cmd_q[0].wr;
                lsu_cmd_addr  = cmd_q[0].addr;
                lsu_cmd_wdata = cmd_q[0].wdata;
                lsu_cmd_wstrb = cmd_q[0].wstrb;
                lsu_cmd_size  = cmd_q[0].size;
            end else begin
                lsu_cmd_vld   = 1'b0;
                lsu_cmd_addr  = $urandom;
                lsu_cmd_write = 1'($urandom_range(0, 1));
            end
            if (mode == 2) lsu_rsp_rdy = ($urandom_range(0, 9) < 7);
            else           lsu_rsp_rdy = (mode == 1);
            @(negedge clk);
            eval_cycle();
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_model();
        exp_q.delete();
        for (int i = 0; i < (1 << TB_AW); i++) ref_mem[i] = '0;
    endtask

    int unsigned acc0;
    int unsigned guard;

    initial begin
        clear_model();
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        check("rst_rdata", lsu_rsp_rdata, 32'd0);
        check("rst_err", 32'(lsu_rsp_err), 32'd0);
        @(posedge clk);
        #1;
        run(2, 1);

        // Word store then read back at BASE+8
        cmd_q.push_back(mk(1'b1, TB_BASE + 32'h8, 32'hDEAD_BEEF, 4'hF, 3'd2));
        cmd_q.push_back(mk(1'b0, TB_BASE + 32'h8, 32'h0, 4'h0, 3'd2));
        run(6, 1);

        // Byte store merges into an existing word
        cmd_q.push_back(mk(1'b1, TB_BASE + 32'h10, 32'h1122_3344, 4'hF, 3'd2));
        cmd_q.push_back(mk(1'b1, TB_BASE + 32'h13, 32'h5A00_0000, 4'b1000, 3'd0));
        cmd_q.push_back(mk(1'b0, TB_BASE + 32'h10, 32'h0, 4'h0, 3'd2));
        run(8, 1);

        // Out-of-window below/above, misaligned half, and a zero-strobe store
        cmd_q.push_back(mk(1'b0, TB_BASE - 32'd4, 32'h0, 4'h0, 3'd2));
        cmd_q.push_back(mk(1'b0, TB_BASE + 32'(TB_WIN), 32'h0, 4'h0, 3'd2));
        cmd_q.push_back(mk(1'b0, TB_BASE + 32'd1, 32'h0, 4'h0, 3'd1));
        cmd_q.push_back(mk(1'b1, TB_BASE + 32'h10, 32'hFFFF_FFFF, 4'h0, 3'd2));
        cmd_q.push_back(mk(1'b0, TB_BASE + 32'h10, 32'h0, 4'h0, 3'd2));
        run(10, 1);

        // Back-to-back reads at full rate
        for (int i = 0; i < 8; i++)
            cmd_q.push_back(mk(1'b0, TB_BASE + 32'(4 * i), 32'h0, 4'h0, 3'd2));
        run(14, 1);

        // Back-pressure: six offered, only four fit
        for (int i = 0; i < 6; i++)
            cmd_q.push_back(mk(1'b0, TB_BASE + 32'(4 * i), 32'h0, 4'h0, 3'd2));
        acc0 = n_acc;
        run(10, 0);
        check("held_accepts", n_acc - acc0, 32'd4);
        run(12, 1);
        check("held_drained", n_acc - acc0, 32'd6);

        // Random traffic with random response back-pressure
        for (int i = 0; i < 400; i++) cmd_q.push_back(rand_cmd());
        guard = 0;
        while (cmd_q.size() > 0 && guard < 4000) begin
            run(1, 2);
            guard++;
        end
        check("rand_left", 32'(cmd_q.size()), 32'd0);
        cmd_q.delete();
        run(20, 1);

        // Reset with three responses buffered
        for (int i = 0; i < 3; i++)
            cmd_q.push_back(mk(1'b0, TB_BASE + 32'(4 * i), 32'h0, 4'h0, 3'd2));
        run(8, 0);
        check("pre_rst_vld", 32'(lsu_rsp_vld), 32'd1);
        lsu_cmd_vld   = 1'b1;
        lsu_cmd_write = 1'b1;
        lsu_cmd_addr  = TB_BASE;
        lsu_cmd_size  = 3'd2;
        lsu_cmd_wstrb = 4'hF;
        #1 reset_n = 1'b0;
        #1;
        check("rst_vld_now", 32'(lsu_rsp_vld), 32'd0);
        check("rst_rdata_now", lsu_rsp_rdata, 32'd0);
        check("rst_err_now", 32'(lsu_rsp_err), 32'd0);
        check("rst_cs_now", 32'(sram_cs), 32'd0);
        check("rst_we_now", 32'(sram_we), 32'd0);
        cmd_q.delete();
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        lsu_cmd_vld = 1'b0;
        reset_n     = 1'b1;
        run(8, 1);

        // A little more random traffic after reset
        for (int i = 0; i < 60; i++) cmd_q.push_back(rand_cmd());
        guard = 0;
        while (cmd_q.size() > 0 && guard < 1000) begin
            run(1, 2);
            guard++;
        end
        check("rand2_left", 32'(cmd_q.size()), 32'd0);
        cmd_q.delete();
        run(20, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
